// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI bus arbiter and its nibble serialiser.
package idli_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      FINISH
   } arb_state_t;

   typedef enum logic {
      OWNER_FE,
      OWNER_MEM
   } arb_owner_t;

   localparam int unsigned SQI_CMD_NIBBLES  = 2;
   localparam int unsigned SQI_ADDR_NIBBLES = 6;
   localparam int unsigned SQI_WORD_NIBBLES = 4;

   // Nibble idx of the 24b bus address {8'h00, addr}, most significant first.
   function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [2:0] idx);
      logic [23:0] sh;
      sh = {8'h00, addr} >> (5'd20 - {idx, 2'b00});
      return sh[3:0];
   endfunction

endpackage

// File: rtl/idli_sqi_ser_m.sv
// Selects the outgoing SQI nibble (command, address or store data) from the
// arbiter's current state and nibble counter.
module idli_sqi_ser_m
   import idli_pkg::*;
#(
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  arb_state_t  state,
   input  logic [2:0]  ctr,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [3:0]  wdata,
   output logic [3:0]  nib
);

   logic [7:0] cmd;

   always_comb begin
      nib = '0;
      cmd = wr ? CMD_WRITE : CMD_READ;
      case (state)
         CMD:     nib = ctr[0] ? cmd[3:0] : cmd[7:4];
         ADDR:    nib = addr_nibble(addr, ctr);
         DATA:    if (wr) nib = wdata;
         default: nib = '0;
      endcase
   end

endmodule

// File: rtl/idli_sqi_arb_m.sv
// SQI SRAM bus owner: arbitrates fetch vs. ex, sequences CS/command/address/
// dummy/data, streams fetch bursts and kills fetch on redirect.
module idli_sqi_arb_m
   import idli_pkg::*;
#(
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02,
   parameter int unsigned DUMMY_N   = 2
) (
   input  logic        i_arb_gck,
   input  logic        i_arb_rst,
   input  logic        i_arb_fe_req,
   input  logic [15:0] i_arb_fe_addr,
   output logic        o_arb_fe_gnt,
   output logic [3:0]  o_arb_fe_data,
   output logic        o_arb_fe_data_vld,
   input  logic        i_arb_mem_req,
   input  logic        i_arb_mem_wr,
   input  logic [15:0] i_arb_mem_addr,
   input  logic [3:0]  i_arb_mem_wdata,
   output logic        o_arb_mem_gnt,
   output logic        o_arb_mem_wdata_acp,
   output logic [3:0]  o_arb_mem_rdata,
   output logic        o_arb_mem_rdata_vld,
   output logic        o_arb_mem_done,
   input  logic        i_arb_redirect,
   output logic        o_arb_sqi_cs_n,
   output logic [3:0]  o_arb_sqi_sio,
   output logic        o_arb_sqi_oe,
   input  logic [3:0]  i_arb_sqi_sio
);

   arb_state_t  state_q, state_d;
   arb_owner_t  owner_q, owner_d;
   logic [2:0]  ctr_q, ctr_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic        cs_n_q, oe_q;
   logic        fe_gnt, mem_gnt, fe_own, last_nib, data_ok;
   logic [3:0]  ser_nib;

   always_comb begin
      fe_own   = (owner_q == OWNER_FE);
      last_nib = (ctr_q == 3'(SQI_WORD_NIBBLES - 1));
      data_ok  = (state_q == DATA) && !i_arb_rst;
      mem_gnt  = (state_q == IDLE) && i_arb_mem_req && !i_arb_rst;
      fe_gnt   = (state_q == IDLE) && i_arb_fe_req && !i_arb_mem_req && !i_arb_redirect && !i_arb_rst;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      ctr_d   = ctr_q + 3'd1;
      case (state_q)
         IDLE: begin
            ctr_d = '0;
            if (mem_gnt) begin
               state_d = CMD;
               owner_d = OWNER_MEM;
               wr_d    = i_arb_mem_wr;
               addr_d  = i_arb_mem_addr;
            end else if (fe_gnt) begin
               state_d = CMD;
               owner_d = OWNER_FE;
               wr_d    = 1'b0;
               addr_d  = i_arb_fe_addr;
            end
         end
         CMD: if (ctr_q == 3'(SQI_CMD_NIBBLES - 1)) begin
            state_d = ADDR;
            ctr_d   = '0;
         end
         ADDR: if (ctr_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
            state_d = wr_q ? DATA : DUMMY;
            ctr_d   = '0;
         end
         DUMMY: if (ctr_q == 3'(DUMMY_N - 1)) begin
            state_d = DATA;
            ctr_d   = '0;
         end
         DATA: if (last_nib) begin
            // Fetch keeps CS low and lets the SRAM auto-increment into the next word.
            ctr_d = '0;
            if (!(fe_own && i_arb_fe_req && !i_arb_mem_req && !i_arb_redirect))
               state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
            ctr_d   = '0;
         end
         default: begin
            state_d = IDLE;
            ctr_d   = '0;
         end
      endcase
      if (fe_own && i_arb_redirect && state_q != IDLE && state_q != FINISH) begin
         state_d = FINISH;
         ctr_d   = '0;
      end
   end

   // Pad controls are registered from the next state so they line up with state_q.
   always_ff @(posedge i_arb_gck) begin
      if (i_arb_rst) begin
         state_q <= IDLE;
         owner_q <= OWNER_FE;
         ctr_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         cs_n_q  <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ctr_q   <= ctr_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         cs_n_q  <= !(state_d inside {CMD, ADDR, DUMMY, DATA});
         oe_q    <= (state_d inside {CMD, ADDR}) || (state_d == DATA && wr_d);
      end
   end

   idli_sqi_ser_m #(
      .CMD_READ  (CMD_READ),
      .CMD_WRITE (CMD_WRITE)
   ) u_ser (
      .state (state_q),
      .ctr   (ctr_q),
      .wr    (wr_q),
      .addr  (addr_q),
      .wdata (i_arb_mem_wdata),
      .nib   (ser_nib)
   );

   assign o_arb_fe_gnt        = fe_gnt;
   assign o_arb_mem_gnt       = mem_gnt;
   assign o_arb_fe_data_vld   = data_ok && fe_own && !i_arb_redirect;
   assign o_arb_mem_rdata_vld = data_ok && !fe_own && !wr_q;
   assign o_arb_mem_wdata_acp = data_ok && !fe_own && wr_q;
   assign o_arb_mem_done      = data_ok && !fe_own && last_nib;
   assign o_arb_fe_data       = o_arb_fe_data_vld ? i_arb_sqi_sio : '0;
   assign o_arb_mem_rdata     = o_arb_mem_rdata_vld ? i_arb_sqi_sio : '0;
   assign o_arb_sqi_cs_n      = cs_n_q;
   assign o_arb_sqi_oe        = oe_q;
   assign o_arb_sqi_sio       = oe_q ? ser_nib : '0;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Self-checking bench for idli_sqi_arb_m: per-cycle bus trace expected from
// the transfer timing rules, with randomized transfer mix and addresses.
module tb_idli_sqi_arb_m;

   logic        clk = 1'b0;
   logic        rst;
   logic        fe_req, mem_req, mem_wr, redirect;
   logic [15:0] fe_addr, mem_addr;
   logic [3:0]  mem_wdata, sio_i;
   logic        fe_gnt, fe_vld, mem_gnt, acp, rvld, done, cs_n, oe;
   logic [3:0]  fe_data, rdata, sio_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   idli_sqi_arb_m dut (
      .i_arb_gck           (clk),
      .i_arb_rst           (rst),
      .i_arb_fe_req        (fe_req),
      .i_arb_fe_addr       (fe_addr),
      .o_arb_fe_gnt        (fe_gnt),
      .o_arb_fe_data       (fe_data),
      .o_arb_fe_data_vld   (fe_vld),
      .i_arb_mem_req       (mem_req),
      .i_arb_mem_wr        (mem_wr),
      .i_arb_mem_addr      (mem_addr),
      .i_arb_mem_wdata     (mem_wdata),
      .o_arb_mem_gnt       (mem_gnt),
      .o_arb_mem_wdata_acp (acp),
      .o_arb_mem_rdata     (rdata),
      .o_arb_mem_rdata_vld (rvld),
      .o_arb_mem_done      (done),
      .i_arb_redirect      (redirect),
      .o_arb_sqi_cs_n      (cs_n),
      .o_arb_sqi_sio       (sio_o),
      .o_arb_sqi_oe        (oe),
      .i_arb_sqi_sio       (sio_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {fe_gnt, mem_gnt, cs_n, oe, sio[3:0], fe_vld, rdata_vld, wdata_acp, done}
   function automatic logic [11:0] bus_vec();
      return {fe_gnt, mem_gnt, cs_n, oe, sio_o, fe_vld, rvld, acp, done};
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         fe_req   = 1'b0;
         mem_req  = 1'b0;
         redirect = 1'(($urandom));
         fe_addr  = 16'($urandom);
         mem_addr = 16'($urandom);
         sio_i    = 4'($urandom);
         #1;
         chk("idle bus", 32'(bus_vec()), 32'h200);
      end
   endtask

   // kind 0=load 1=store 2=fetch; rc = redirect cycle rel. to grant (-1 none);
   // mc = data nibble index where ex starts requesting during fetch (-1 none);
   // fe_hold keeps fe_req high through an ex transfer.
   task automatic run_xfer(input int kind, input logic [15:0] a, input int n, input int rc,
                           input int mc, input bit fe_hold, input logic [47:0] dat);
      bit wr, fe, dcyc, vld, hdr;
      int ds, last, k;
      logic [23:0] a24;
      logic [3:0]  nib, esio;
      logic [11:0] e;
      wr  = (kind == 1);
      fe  = (kind == 2);
      ds  = wr ? 9 : 11;
      a24 = {8'h00, a};
      if (!fe)          last = ds + 3;
      else if (rc >= 0) last = rc;
      else if (mc >= 0) last = ds + 4 * (mc / 4) + 3;
      else              last = ds + 4 * n - 1;
      for (int t = 0; t <= last + 1; t++) begin
         @(negedge clk);
         dcyc = (t >= ds) && (t <= last);
         k    = t - ds;
         if (dcyc) nib = dat[4*k +: 4];
         else      nib = 4'($urandom);
         fe_req    = fe ? ((mc >= 0) || (t < last)) : fe_hold;
         mem_req   = fe ? ((mc >= 0) && (t >= ds + mc)) : (t == 0);
         redirect  = fe ? ((rc >= 0) && (t == rc)) : ($urandom_range(3, 0) == 0);
         mem_wr    = (t == 0 && !fe) ? wr : 1'($urandom);
         mem_addr  = (t == 0 && !fe) ? a : 16'($urandom);
         fe_addr   = (t == 0 && fe) ? a : 16'($urandom);
         mem_wdata = nib;
         sio_i     = nib;
         #1;
         vld  = dcyc && !(fe && rc >= 0 && t == last);
         hdr  = (t >= 1) && (t <= 8) && (t <= last);
         esio = 4'h0;
         if (hdr && t == 2)      esio = wr ? 4'h2 : 4'h3;
         else if (hdr && t >= 3) esio = 4'(a24 >> (20 - 4 * (t - 3)));
         else if (wr && dcyc)    esio = nib;
         e = {(t == 0) && fe, (t == 0) && !fe, (t == 0) || (t == last + 1), hdr || (wr && dcyc),
              esio, vld && fe, vld && !fe && !wr, vld && wr, !fe && (t == last)};
         chk($sformatf("k%0d a%h t%0d bus", kind, a, t), 32'(bus_vec()), 32'(e));
         if (vld && fe)        chk($sformatf("t%0d fe_data", t), 32'(fe_data), 32'(nib));
         if (vld && !fe && !wr) chk($sformatf("t%0d rdata", t), 32'(rdata), 32'(nib));
      end
   endtask

   task automatic reset_mid_load();
      for (int t = 0; t <= 12; t++) begin
         @(negedge clk);
         rst      = (t == 12);
         mem_req  = (t == 0);
         mem_wr   = 1'b0;
         mem_addr = 16'h4444;
         fe_req   = 1'b0;
         redirect = 1'b0;
         sio_i    = 4'($urandom);
         #1;
         if (t == 12) chk("rst cycle done", 32'(done), 32'h0);
      end
      for (int t = 13; t <= 14; t++) begin
         @(negedge clk);
         rst     = 1'b0;
         mem_req = 1'b0;
         #1;
         chk($sformatf("rst t%0d bus", t), 32'(bus_vec()), 32'h200);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          pend_mem, pend_fe, chain, fh;
      int          kind, n, rc, mc;
      logic [15:0] a;
      logic [47:0] d;
      rst = 1'b1; fe_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; redirect = 1'b0;
      fe_addr = '0; mem_addr = '0; mem_wdata = '0; sio_i = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("reset bus", 32'(bus_vec()), 32'h200);
         chk("reset data", 32'({fe_data, rdata}), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(4);

      run_xfer(0, 16'h1234, 1, -1, -1, 1'b0, 48'h1234);
      idle_cycles(1);
      run_xfer(1, 16'h0010, 1, -1, -1, 1'b1, 48'hDCBA);
      run_xfer(2, 16'h0100, 3, -1, -1, 1'b0, 48'h9A8B_7C6D_5E4F);
      idle_cycles(2);
      run_xfer(2, 16'h0200, 2, 12, -1, 1'b0, 48'h0000_1357_9BDF);
      run_xfer(2, 16'h0300, 1, -1, -1, 1'b0, 48'h0000_0000_2468);
      run_xfer(2, 16'h0400, 3, -1, 6, 1'b0, 48'h3C3C_A5A5_F00F);
      run_xfer(0, 16'h0500, 1, -1, -1, 1'b1, 48'h0000_0000_8421);
      run_xfer(2, 16'h0600, 1, -1, -1, 1'b0, 48'h0000_0000_E1D2);
      reset_mid_load();

      pend_mem = 1'b0;
      pend_fe  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         chain = (i < 29);
         a     = 16'($urandom);
         n     = int'($urandom_range(3, 1));
         d     = {16'($urandom), 32'($urandom)};
         rc    = -1;
         mc    = -1;
         if (pend_mem)     kind = int'($urandom_range(1, 0));
         else if (pend_fe) kind = 2;
         else begin
            idle_cycles(int'($urandom_range(2, 0)));
            kind = int'($urandom_range(2, 0));
         end
         if (kind == 2) begin
            if ($urandom_range(3, 0) == 0)
               rc = int'($urandom_range(11 + 4 * n - 1, 1));
            else if (chain && $urandom_range(3, 0) == 0)
               mc = int'($urandom_range(4 * n - 1, 0));
            run_xfer(2, a, n, rc, mc, 1'b0, d);
            pend_mem = (mc >= 0);
            pend_fe  = (mc >= 0);
         end else begin
            fh = pend_fe || (chain && $urandom_range(3, 0) == 0);
            run_xfer(kind, a, 1, -1, -1, fh, d);
            pend_mem = 1'b0;
            pend_fe  = fh;
         end
      end
      if (pend_fe) run_xfer(2, 16'h0F00, 1, -1, -1, 1'b0, 48'h0000_0000_5A5A);
      idle_cycles(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
